// File: rtl/jtag_tap_master.sv
// Host-side JTAG initiator: sequences TCK/TMS/TDI for TAP reset, IR/DR shifts and
// Run-Test/Idle clocking, and returns captured TDO bits on a one-cycle response strobe.
module jtag_tap_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [5:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(MAX_LEN + 8);
  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpIr    = 2'b01;
  localparam logic [1:0] OpRun   = 2'b11;

  typedef enum logic [2:0] {StRstSeq, StIdle, StHdr, StShift, StTrl, StDone} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic [CntW-1:0]     bit_q, bit_d;
  logic                prime_q, prime_d;
  logic [1:0]          op_q, op_d;
  logic [CntW-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0]  data_q, data_d;
  logic [MAX_LEN-1:0]  cap_q, cap_d;
  logic [MAX_LEN-1:0]  rsp_q, rsp_d;

  logic [CntW-1:0]     eff_len;
  logic [CntW-1:0]     seg_len;
  logic                tck_fall;
  logic                tck_rise;
  state_e              nxt_state;
  logic [CntW-1:0]     nxt_bit;
  logic                nxt_tms;
  logic                nxt_tdi;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StRstSeq;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      bit_q   <= '0;
      prime_q <= 1'b1;
      op_q    <= OpReset;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      bit_q   <= bit_d;
      prime_q <= prime_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    if (cmd_len_i == 6'd0) begin
      eff_len = CntW'(1);
    end else if (32'(cmd_len_i) > MAX_LEN) begin
      eff_len = CntW'(MAX_LEN);
    end else begin
      eff_len = CntW'(cmd_len_i);
    end
  end

  // Number of TCK cycles in the segment the current state is clocking out.
  always_comb begin
    case (state_q)
      StRstSeq: seg_len = CntW'(6);
      StHdr:    seg_len = (op_q == OpIr) ? CntW'(4) : CntW'(3);
      StShift:  seg_len = len_q;
      default:  seg_len = CntW'(2);
    endcase
  end

  // prime_q marks the edge that launches the first bit of a segment chain, with no
  // preceding high phase to end and no TDO to sample.
  assign tck_fall = prime_q || (tck_q && (div_q == DivLast));
  assign tck_rise = !prime_q && !tck_q && (div_q == DivLast);

  always_comb begin
    nxt_state = state_q;
    nxt_bit   = bit_q + CntW'(1);
    if (prime_q) begin
      nxt_bit = '0;
    end else if (nxt_bit >= seg_len) begin
      nxt_bit = '0;
      case (state_q)
        StHdr:   nxt_state = StShift;
        StShift: nxt_state = (op_q == OpRun) ? StDone : StTrl;
        default: nxt_state = StDone;
      endcase
    end
  end

  always_comb begin
    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    case (nxt_state)
      StRstSeq: nxt_tms = (nxt_bit < CntW'(5));
      StHdr:    nxt_tms = (op_q == OpIr) ? (nxt_bit < CntW'(2)) : (nxt_bit == '0);
      StShift: begin
        if (op_q != OpRun) begin
          nxt_tms = (nxt_bit == (len_q - CntW'(1)));
          nxt_tdi = data_q[nxt_bit[IdxW-1:0]];
        end
      end
      StTrl:    nxt_tms = (nxt_bit == '0);
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    bit_d   = bit_q;
    prime_d = prime_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    case (state_q)
      StIdle: begin
        tck_d = 1'b0;
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          len_d   = eff_len;
          data_d  = cmd_data_i;
          cap_d   = '0;
          prime_d = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          case (cmd_op_i)
            OpReset: state_d = StRstSeq;
            OpRun:   state_d = StShift;
            default: state_d = StHdr;
          endcase
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        if (tck_fall) begin
          prime_d = 1'b0;
          tck_d   = 1'b0;
          div_d   = '0;
          if (!prime_q && (state_q == StShift) && (op_q != OpRun)) begin
            cap_d[bit_q[IdxW-1:0]] = tdo_i;
          end
          if (nxt_state == StDone) begin
            // Completion always lands in TRL, RST_SEQ or a run-idle SHIFT, none of
            // which write cap on this edge, so cap_q is already final.
            state_d = StDone;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            rsp_d   = cap_q;
          end else begin
            state_d = nxt_state;
            bit_d   = nxt_bit;
            tms_d   = nxt_tms;
            tdi_d   = nxt_tdi;
          end
        end else if (tck_rise) begin
          tck_d = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    rsp_valid_o = (state_q == StDone);
    rsp_data_o  = rsp_q;
    tck_o       = tck_q;
    tms_o       = tms_q;
    tdi_o       = tdi_q;
  end

endmodule
